// File: rtl/test_result_collector_pkg.sv
// Shared types and helpers for the test result collector: FSM states,
// the aggregated summary record and a bitmap popcount.
package test_result_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REPORT  = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Summary fields are held at a fixed maximum width; instances slice
  // their own CNT_W bits out of each field.
  localparam int SUM_CNT_W = 32;
  localparam int MAX_TESTS = 64;

  typedef struct packed {
    logic [SUM_CNT_W-1:0] passed;
    logic [SUM_CNT_W-1:0] failed;
    logic [SUM_CNT_W-1:0] missing;
    logic [SUM_CNT_W-1:0] dup;
    logic [SUM_CNT_W-1:0] bad_id;
    logic                 verdict;
  } summary_t;

  function automatic int unsigned popcount(input logic [MAX_TESTS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_TESTS; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/test_result_collector_if.sv
// Result-record and summary channels between test sequencers (master)
// and the result collector (slave).
interface test_result_collector_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  // Both channels use strict valid/ready: a transfer happens on a rising
  // edge where valid && ready; once raised, valid and its payload hold
  // until that edge, and ready never depends combinationally on valid.
  logic             res_valid;
  logic             res_ready;
  logic [ID_W-1:0]  res_id;
  logic             res_pass;
  logic             finish_req;
  logic             restart;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] sum_passed;
  logic [CNT_W-1:0] sum_failed;
  logic [CNT_W-1:0] sum_missing;
  logic [CNT_W-1:0] sum_dup;
  logic [CNT_W-1:0] sum_bad_id;
  logic             sum_verdict;
  logic             busy;

  modport master (
    output res_valid, res_id, res_pass, finish_req, restart, sum_ready,
    input  res_ready, sum_valid, sum_passed, sum_failed, sum_missing,
           sum_dup, sum_bad_id, sum_verdict, busy
  );

  modport slave (
    input  res_valid, res_id, res_pass, finish_req, restart, sum_ready,
    output res_ready, sum_valid, sum_passed, sum_failed, sum_missing,
           sum_dup, sum_bad_id, sum_verdict, busy
  );
endinterface

// File: rtl/test_result_collector_sat_counter.sv
// Saturating up-counter with clear and parallel load; cnt_nxt exposes the
// value the counter takes at the coming edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/test_result_collector.sv
// Collects per-test pass/fail records, tracks which ids have reported and
// emits one aggregated summary when all ids are in or a finish is forced.
module test_result_collector
  import test_result_pkg::*;
#(
  parameter int N_TESTS = 4,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  test_result_collector_if.slave bus,
  output state_e                state_dbg
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  state_e             state_q, state_d;
  logic               res_ready_q, res_ready_d;
  logic               sum_valid_q, sum_valid_d;
  logic               busy_q, busy_d;
  logic               verdict_q, verdict_d;
  logic [N_TESTS-1:0] seen_q, seen_d;
  logic [N_TESTS-1:0] id_hit;

  logic accept, is_bad, is_dup, is_new;
  logic go_report, clr_all;
  int   missing_raw;
  logic [CNT_W-1:0] missing_load;

  logic [CNT_W-1:0] passed_cnt, failed_cnt, missing_cnt, dup_cnt, bad_cnt;
  logic [CNT_W-1:0] passed_nxt, failed_nxt, missing_nxt, dup_nxt, bad_nxt;

  // An in-range id hits exactly one bitmap position; no hit means bad id.
  always_comb begin
    id_hit = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      id_hit[i] = (bus.res_id == ID_W'(i));
    end
  end

  assign accept  = bus.res_valid && res_ready_q;
  assign is_bad  = (id_hit == '0);
  assign is_dup  = |(id_hit & seen_q);
  assign is_new  = !is_bad && !is_dup;
  assign clr_all = (state_q == DONE) && bus.restart;

  always_comb begin
    seen_d = seen_q;
    if (clr_all) begin
      seen_d = '0;
    end else if (accept) begin
      seen_d = seen_q | id_hit;
    end
  end

  assign go_report = (state_q == COLLECT) && ((&seen_d) || bus.finish_req);

  always_comb begin
    missing_raw  = N_TESTS - int'(popcount(MAX_TESTS'(seen_d)));
    missing_load = (missing_raw > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(missing_raw);
  end

  sat_counter #(.W(CNT_W)) u_passed (
    .clk(clk), .reset_n(reset_n), .clr(clr_all),
    .inc(accept && is_new && bus.res_pass), .load(1'b0), .load_val('0),
    .cnt(passed_cnt), .cnt_nxt(passed_nxt)
  );

  sat_counter #(.W(CNT_W)) u_failed (
    .clk(clk), .reset_n(reset_n), .clr(clr_all),
    .inc(accept && is_new && !bus.res_pass), .load(1'b0), .load_val('0),
    .cnt(failed_cnt), .cnt_nxt(failed_nxt)
  );

  sat_counter #(.W(CNT_W)) u_missing (
    .clk(clk), .reset_n(reset_n), .clr(clr_all),
    .inc(1'b0), .load(go_report), .load_val(missing_load),
    .cnt(missing_cnt), .cnt_nxt(missing_nxt)
  );

  sat_counter #(.W(CNT_W)) u_dup (
    .clk(clk), .reset_n(reset_n), .clr(clr_all),
    .inc(accept && is_dup), .load(1'b0), .load_val('0),
    .cnt(dup_cnt), .cnt_nxt(dup_nxt)
  );

  sat_counter #(.W(CNT_W)) u_bad_id (
    .clk(clk), .reset_n(reset_n), .clr(clr_all),
    .inc(accept && is_bad), .load(1'b0), .load_val('0),
    .cnt(bad_cnt), .cnt_nxt(bad_nxt)
  );

  // Verdict is judged on the post-edge counter values so a record that
  // lands together with finish_req is already included.
  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    case (state_q)
      COLLECT: begin
        if (go_report) begin
          state_d   = REPORT;
          verdict_d = (32'(passed_nxt) == N_TESTS) && (failed_nxt == '0) &&
                      (dup_nxt == '0) && (bad_nxt == '0) && (missing_nxt == '0);
        end
      end
      REPORT: begin
        if (bus.sum_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.restart) begin
          state_d   = COLLECT;
          verdict_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
    res_ready_d = (state_d == COLLECT);
    busy_d      = (state_d == COLLECT);
    sum_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      res_ready_q <= 1'b1;
      busy_q      <= 1'b1;
      sum_valid_q <= 1'b0;
      verdict_q   <= 1'b0;
      seen_q      <= '0;
    end else begin
      state_q     <= state_d;
      res_ready_q <= res_ready_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
      verdict_q   <= verdict_d;
      seen_q      <= seen_d;
    end
  end

  summary_t sum_view;

  always_comb begin
    sum_view         = '0;
    sum_view.passed  = SUM_CNT_W'(passed_cnt);
    sum_view.failed  = SUM_CNT_W'(failed_cnt);
    sum_view.missing = SUM_CNT_W'(missing_cnt);
    sum_view.dup     = SUM_CNT_W'(dup_cnt);
    sum_view.bad_id  = SUM_CNT_W'(bad_cnt);
    sum_view.verdict = verdict_q;
  end

  assign bus.res_ready   = res_ready_q;
  assign bus.sum_valid   = sum_valid_q;
  assign bus.busy        = busy_q;
  assign bus.sum_passed  = sum_view.passed[CNT_W-1:0];
  assign bus.sum_failed  = sum_view.failed[CNT_W-1:0];
  assign bus.sum_missing = sum_view.missing[CNT_W-1:0];
  assign bus.sum_dup     = sum_view.dup[CNT_W-1:0];
  assign bus.sum_bad_id  = sum_view.bad_id[CNT_W-1:0];
  assign bus.sum_verdict = sum_view.verdict;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_test_result_collector.sv
// Drives two collectors (CNT_W=8 and CNT_W=2) with identical stimulus and
// checks both against a record-level reference model.
module tb_test_result_collector;
  import test_result_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       res_valid = 1'b0;
  logic [3:0] res_id = '0;
  logic       res_pass = 1'b0;
  logic       finish_req = 1'b0;
  logic       restart = 1'b0;
  logic       sum_ready = 1'b0;

  test_result_collector_if #(.ID_W(4), .CNT_W(8)) if_a ();
  test_result_collector_if #(.ID_W(4), .CNT_W(2)) if_b ();

  assign if_a.res_valid  = res_valid;
  assign if_a.res_id     = res_id;
  assign if_a.res_pass   = res_pass;
  assign if_a.finish_req = finish_req;
  assign if_a.restart    = restart;
  assign if_a.sum_ready  = sum_ready;
  assign if_b.res_valid  = res_valid;
  assign if_b.res_id     = res_id;
  assign if_b.res_pass   = res_pass;
  assign if_b.finish_req = finish_req;
  assign if_b.restart    = restart;
  assign if_b.sum_ready  = sum_ready;

  state_e st_a, st_b;

  test_result_collector #(.N_TESTS(4), .ID_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave), .state_dbg(st_a)
  );
  test_result_collector #(.N_TESTS(4), .ID_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave), .state_dbg(st_b)
  );

  logic [40:0] sum_a, sum_b;
  assign sum_a = {if_a.sum_passed, if_a.sum_failed, if_a.sum_missing,
                  if_a.sum_dup, if_a.sum_bad_id, if_a.sum_verdict};
  assign sum_b = {6'd0, if_b.sum_passed, 6'd0, if_b.sum_failed, 6'd0, if_b.sum_missing,
                  6'd0, if_b.sum_dup, 6'd0, if_b.sum_bad_id, if_b.sum_verdict};

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  bit m_seen[4];
  int m_pass, m_fail, m_dup, m_bad;

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    m_pass = 0; m_fail = 0; m_dup = 0; m_bad = 0;
  endfunction

  function automatic void model_accept(int id, bit p);
    if (id >= 4) m_bad++;
    else if (m_seen[id]) m_dup++;
    else begin
      m_seen[id] = 1'b1;
      if (p) m_pass++; else m_fail++;
    end
  endfunction

  function automatic int model_nseen();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_seen[i]);
    return n;
  endfunction

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [40:0] model_sum(int w);
    int  p = sat(m_pass, w);
    int  f = sat(m_fail, w);
    int  m = sat(4 - model_nseen(), w);
    int  d = sat(m_dup, w);
    int  b = sat(m_bad, w);
    bit  v = (p == 4) && (f == 0) && (d == 0) && (b == 0);
    return {8'(p), 8'(f), 8'(m), 8'(d), 8'(b), v};
  endfunction

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q[$];
  logic [40:0] ea, eb;

  function automatic void push_expected();
    exp_q.push_back(model_sum(8));
    exp_q.push_back(model_sum(2));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_rec(input int id, input bit p, input bit fin);
    @(negedge clk);
    res_valid = 1'b1; res_id = 4'(id); res_pass = p; finish_req = fin;
    restart = 1'b0; sum_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic finish_pulse();
    @(negedge clk);
    res_valid = 1'b0; finish_req = 1'b1; restart = 1'b0; sum_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    res_valid = 1'b0; finish_req = 1'b0; restart = 1'b0; sum_ready = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    res_valid = 1'b0; finish_req = 1'b0; restart = 1'b0; sum_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    res_valid = 1'b0; finish_req = 1'b0; restart = 1'b1; sum_ready = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    model_clear();
    total++; if (if_a.res_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", if_a.res_ready); end
    total++; if (if_a.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", if_a.busy); end
    total++; if (if_a.sum_valid !== 1'b0) begin bad++; $display("FAIL reset_sum_valid: got %b want 0", if_a.sum_valid); end
    total++; if (sum_a !== 41'd0) begin bad++; $display("FAIL reset_sum_a: got %h want 0", sum_a); end
    total++; if (sum_b !== 41'd0) begin bad++; $display("FAIL reset_sum_b: got %h want 0", sum_b); end
  endtask

  task automatic test_all_pass();
    model_clear();
    for (int i = 0; i < 3; i++) begin send_rec(i, 1'b1, 1'b0); model_accept(i, 1'b1); end
    #1;
    total++; if (if_a.sum_valid !== 1'b0) begin bad++; $display("FAIL allpass_early_valid: got %b want 0", if_a.sum_valid); end
    send_rec(3, 1'b1, 1'b0); model_accept(3, 1'b1);
    settle();
    push_expected();
    total++; if (if_a.sum_valid !== 1'b1) begin bad++; $display("FAIL allpass_valid: got %b want 1", if_a.sum_valid); end
    total++; if (if_a.res_ready !== 1'b0) begin bad++; $display("FAIL allpass_ready: got %b want 0", if_a.res_ready); end
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    total++; if (sum_a !== ea) begin bad++; $display("FAIL allpass_sum_a: got %h want %h", sum_a, ea); end
    total++; if (sum_b !== eb) begin bad++; $display("FAIL allpass_sum_b: got %h want %h", sum_b, eb); end
    total++; if (if_a.sum_verdict !== 1'b1) begin bad++; $display("FAIL allpass_verdict: got %b want 1", if_a.sum_verdict); end
    ack(); settle();
    total++; if ({if_a.sum_valid, if_a.busy, if_a.res_ready} !== 3'b000) begin bad++; $display("FAIL allpass_done: got %b want 000", {if_a.sum_valid, if_a.busy, if_a.res_ready}); end
    do_restart(); settle(); model_clear();
    total++; if ({if_a.busy, if_a.res_ready} !== 2'b11) begin bad++; $display("FAIL allpass_restart: got %b want 11", {if_a.busy, if_a.res_ready}); end
    total++; if (sum_a[40:1] !== 40'd0) begin bad++; $display("FAIL allpass_restart_cnt: got %h want 0", sum_a[40:1]); end
  endtask

  task automatic test_one_fail();
    model_clear();
    for (int i = 0; i < 4; i++) begin send_rec(i, i != 3, 1'b0); model_accept(i, i != 3); end
    settle(); push_expected();
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    total++; if (sum_a !== ea) begin bad++; $display("FAIL onefail_sum_a: got %h want %h", sum_a, ea); end
    total++; if (sum_b !== eb) begin bad++; $display("FAIL onefail_sum_b: got %h want %h", sum_b, eb); end
    ack(); do_restart(); settle();
  endtask

  task automatic test_dup_bad();
    model_clear();
    send_rec(0, 1'b1, 1'b0); model_accept(0, 1'b1);
    send_rec(0, 1'b0, 1'b0); model_accept(0, 1'b0);
    send_rec(5, 1'b1, 1'b0); model_accept(5, 1'b1);
    finish_pulse(); settle(); push_expected();
    total++; if (if_a.sum_valid !== 1'b1) begin bad++; $display("FAIL dupbad_valid: got %b want 1", if_a.sum_valid); end
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    total++; if (sum_a !== ea) begin bad++; $display("FAIL dupbad_sum_a: got %h want %h", sum_a, ea); end
    total++; if (sum_b !== eb) begin bad++; $display("FAIL dupbad_sum_b: got %h want %h", sum_b, eb); end
    ack(); do_restart(); settle();
  endtask

  task automatic test_finish_same_cycle();
    model_clear();
    send_rec(0, 1'b1, 1'b0); model_accept(0, 1'b1);
    send_rec(1, 1'b1, 1'b0); model_accept(1, 1'b1);
    send_rec(2, 1'b1, 1'b1); model_accept(2, 1'b1);
    settle(); push_expected();
    total++; if (if_a.res_ready !== 1'b0) begin bad++; $display("FAIL samecyc_ready: got %b want 0", if_a.res_ready); end
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    total++; if (sum_a !== ea) begin bad++; $display("FAIL samecyc_sum_a: got %h want %h", sum_a, ea); end
    total++; if (sum_b !== eb) begin bad++; $display("FAIL samecyc_sum_b: got %h want %h", sum_b, eb); end
    ack(); do_restart(); settle();
  endtask

  task automatic test_hold();
    model_clear();
    send_rec(1, 1'b0, 1'b0); model_accept(1, 1'b0);
    send_rec(2, 1'b1, 1'b0); model_accept(2, 1'b1);
    finish_pulse(); settle(); push_expected();
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if ({if_a.sum_valid, if_a.res_ready} !== 2'b10) begin bad++; $display("FAIL hold_hs c%0d: got %b want 10", c, {if_a.sum_valid, if_a.res_ready}); end
      total++; if (sum_a !== ea) begin bad++; $display("FAIL hold_sum_a c%0d: got %h want %h", c, sum_a, ea); end
      total++; if (sum_b !== eb) begin bad++; $display("FAIL hold_sum_b c%0d: got %h want %h", c, sum_b, eb); end
      res_valid = 1'($urandom_range(0, 1)); res_id = 4'($urandom_range(0, 7));
      res_pass = 1'($urandom_range(0, 1)); finish_req = 1'($urandom_range(0, 1));
      sum_ready = 1'b0;
    end
    ack(); settle();
    total++; if ({if_a.sum_valid, if_a.busy} !== 2'b00) begin bad++; $display("FAIL hold_done: got %b want 00", {if_a.sum_valid, if_a.busy}); end
    total++; if (sum_a !== ea) begin bad++; $display("FAIL hold_done_keep: got %h want %h", sum_a, ea); end
    do_restart(); settle(); model_clear();
    total++; if ({if_a.busy, if_a.res_ready} !== 2'b11) begin bad++; $display("FAIL hold_restart: got %b want 11", {if_a.busy, if_a.res_ready}); end
    total++; if (sum_a[40:1] !== 40'd0) begin bad++; $display("FAIL hold_restart_cnt: got %h want 0", sum_a[40:1]); end
  endtask

  task automatic test_reset_in_report();
    model_clear();
    send_rec(0, 1'b1, 1'b0); model_accept(0, 1'b1);
    send_rec(3, 1'b0, 1'b0); model_accept(3, 1'b0);
    finish_pulse(); settle();
    total++; if (if_a.sum_valid !== 1'b1) begin bad++; $display("FAIL rstrep_pre: got %b want 1", if_a.sum_valid); end
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    model_clear();
    total++; if ({if_a.sum_valid, if_a.res_ready, if_a.busy} !== 3'b011) begin bad++; $display("FAIL rstrep_hs: got %b want 011", {if_a.sum_valid, if_a.res_ready, if_a.busy}); end
    total++; if (sum_a !== 41'd0) begin bad++; $display("FAIL rstrep_sum_a: got %h want 0", sum_a); end
    total++; if (sum_b !== 41'd0) begin bad++; $display("FAIL rstrep_sum_b: got %h want 0", sum_b); end
  endtask

  task automatic test_saturation();
    model_clear();
    send_rec(0, 1'b1, 1'b0); model_accept(0, 1'b1);
    for (int i = 0; i < 5; i++) begin send_rec(0, 1'b1, 1'b0); model_accept(0, 1'b1); end
    for (int i = 0; i < 5; i++) begin send_rec(9, 1'b0, 1'b0); model_accept(9, 1'b0); end
    finish_pulse(); settle(); push_expected();
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    total++; if (sum_a !== ea) begin bad++; $display("FAIL sat_sum_a: got %h want %h", sum_a, ea); end
    total++; if (sum_b !== eb) begin bad++; $display("FAIL sat_sum_b: got %h want %h", sum_b, eb); end
    total++; if (if_b.sum_dup !== 2'd3) begin bad++; $display("FAIL sat_dup_b: got %0d want 3", if_b.sum_dup); end
    ack(); do_restart(); settle();
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int  len;
      bit  fin_last, fin_sent;
      int  id;
      bit  p;
      int  dly;
      model_clear();
      len = $urandom_range(1, 12);
      fin_last = 1'($urandom_range(0, 1));
      fin_sent = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (model_nseen() == 4) break;
        id = $urandom_range(0, 7);
        p = 1'($urandom_range(0, 1));
        fin_sent = fin_last && (i == len - 1);
        send_rec(id, p, fin_sent);
        model_accept(id, p);
      end
      if ((model_nseen() != 4) && !fin_sent) finish_pulse();
      settle(); push_expected();
      total++; if (if_a.sum_valid !== 1'b1) begin bad++; $display("FAIL rnd%0d_valid: got %b want 1", s, if_a.sum_valid); end
      dly = $urandom_range(0, 3);
      repeat (dly) @(posedge clk);
      @(negedge clk);
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      total++; if (sum_a !== ea) begin bad++; $display("FAIL rnd%0d_sum_a: got %h want %h", s, sum_a, ea); end
      total++; if (sum_b !== eb) begin bad++; $display("FAIL rnd%0d_sum_b: got %h want %h", s, sum_b, eb); end
      ack(); settle();
      total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_busy: got %b want 0", s, if_a.busy); end
      do_restart();
    end
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_all_pass();
    test_one_fail();
    test_dup_bad();
    test_finish_same_cycle();
    test_hold();
    test_reset_in_report();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/test_result_collector.md
Name: test_result_collector

Overview:
Receiving end of the per-test pass/fail reporting flow. Test-side logic emits one result record per test (test_id, pass/fail); this block accepts those records over a valid/ready handshake and tracks which tests have reported. When every expected test has reported, or when a finish is requested, it produces one aggregated summary record with an overall verdict. It sits between the test sequencers and the top-level status/finish logic of the self-checking test harness.

Parameters:
N_TESTS, 4, number of expected test ids (0..N_TESTS-1); must be >= 2
ID_W, 4, width of the test id field; must satisfy 2**ID_W > N_TESTS so that out-of-range ids are representable
CNT_W, 8, width of each summary counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
res_valid  in  1  result record valid
res_ready  out  1  result record accepted when res_valid && res_ready
res_id  in  ID_W  test id of the record
res_pass  in  1  1 = TEST_PASSED, 0 = TEST_FAILED
finish_req  in  1  force summary now (single-cycle pulse or level)
restart  in  1  in DONE: clear all state and collect again
sum_valid  out  1  summary valid
sum_ready  in  1  summary consumed when sum_valid && sum_ready
sum_passed  out  CNT_W  count of first-time passing records
sum_failed  out  CNT_W  count of first-time failing records
sum_missing  out  CNT_W  count of ids 0..N_TESTS-1 never reported
sum_dup  out  CNT_W  count of repeat records for an already-seen id
sum_bad_id  out  CNT_W  count of records with res_id >= N_TESTS
sum_verdict  out  1  1 only if passed==N_TESTS, failed==0, dup==0, bad_id==0
busy  out  1  1 in the COLLECT state

Behaviour:
- Reset (reset_n==0 at a rising clk edge) forces: state=COLLECT, seen bitmap=0, all counters=0, sum_valid=0, sum_verdict=0. After reset: res_ready=1 and busy=1. Reset has priority over everything, including in REPORT with sum_valid high; the pending summary is dropped.
- States: COLLECT, REPORT, DONE.
- COLLECT:
  - res_ready=1 and sum_valid=0.
  - On accept, the record is classified in priority order:
    - res_id >= N_TESTS: bad_id++.
    - seen[res_id]==1: dup++, and the result is ignored.
    - Otherwise: set seen[res_id]; passed++ if res_pass, else failed++.
  - All counters saturate at 2**CNT_W-1 and never wrap.
- Transition COLLECT->REPORT at the clock edge where either of these holds:
  - (a) after this edge's update, all N_TESTS seen bits are set; or
  - (b) finish_req==1.
  - A record accepted in the same cycle as finish_req is counted before the summary is frozen.
- Summary latency: sum_valid rises in the cycle after the edge that completes the last id, or after finish_req is sampled. At that point the summary outputs are registered and stable.
- sum_missing = N_TESTS minus popcount(seen), computed when entering REPORT.
- REPORT:
  - res_ready=0.
  - sum_valid=1, and all sum_* outputs stay constant until the handshake completes.
  - On sum_valid && sum_ready: go to DONE and drop sum_valid the next cycle.
  - finish_req is ignored.
- DONE:
  - res_ready=0, sum_valid=0, busy=0. sum_* outputs keep their last values.
  - restart==1 clears the bitmap and counters and returns to COLLECT (res_ready=1 the next cycle).
  - restart is ignored in COLLECT and REPORT.
- Output conditions:
  - sum_verdict is computed only on entry to REPORT; it is 0 at all other times until the first summary.
  - busy is purely a function of state.
  - res_ready does not depend combinationally on res_valid.

Decomposition:
- Package test_result_pkg:
  - state enum (COLLECT, REPORT, DONE);
  - a packed summary struct {passed, failed, missing, dup, bad_id, verdict} parameterised through CNT_W constants.
- One sub-module, sat_counter (width parameter, inc/clr inputs, saturating). It is instantiated five times; the missing count is loaded rather than incremented.
- The popcount is a function in the package.

Test Plan:
- N_TESTS=4: ids 0,1,2,3 all pass, back-to-back -> sum_valid rises 1 cycle after the id-3 accept; passed=4, failed=0, missing=0, dup=0, bad_id=0, verdict=1.
- Ids 0,1,2 pass and id 3 fails -> failed=1, passed=3, verdict=0.
- Ids 0 pass, 0 fail, 5, then finish_req -> passed=1, dup=1, bad_id=1, missing=3, verdict=0; the second record for id 0 does not change passed/failed.
- finish_req in the same cycle as the accept of id 2 (ids 0,1 already seen) -> passed=3, missing=1; res_ready=0 from the next cycle.
- Hold sum_ready=0 for 10 cycles in REPORT while toggling res_valid and finish_req -> summary stable, no record accepted; sum_ready=1 -> DONE; restart -> counters 0, busy=1.
- Assert reset_n=0 for 1 cycle during REPORT -> next cycle sum_valid=0, res_ready=1, all counters 0. With CNT_W=2, send 5 duplicate records -> dup saturates at 3.
